// File: rtl/bus_master.sv
// bus_master: single-outstanding CPU-to-shared-bus access sequencer (IDLE/ACCESS/DONE).
// Define BUS_RANGE_CHECK_EN to fault addresses outside MAP_START..MAP_START+MAP_SIZE-1 without touching the bus.
module bus_master #(
  parameter int WAIT_CYCLES = 0,
  parameter int MAP_START = 0,
  parameter int MAP_SIZE = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy,
  output logic [19:0] bus_addr,
  inout  wire  [15:0] bus_data,
  output logic        read,
  output logic        write
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  state_e state_q;
  logic [3:0] cnt_q;
  logic [15:0] rdata_q, wdata_q;
  logic [19:0] bus_addr_q;
  logic ack_q, err_q, read_q, write_q, fault;
`ifdef BUS_RANGE_CHECK_EN
  localparam logic [20:0] LO = 21'(MAP_START);
  localparam logic [20:0] HI = 21'(MAP_START + MAP_SIZE - 1);
  assign fault = ({1'b0, addr} < LO) || ({1'b0, addr} > HI);
`else
  logic unused_map;
  assign unused_map = ^{MAP_START, MAP_SIZE};
  assign fault = 1'b0;
`endif
  assign rdata = rdata_q;
  assign ack = ack_q;
  assign err = err_q;
  assign busy = state_q != IDLE;
  assign bus_addr = bus_addr_q;
  assign read = read_q;
  assign write = write_q;
  assign bus_data = write_q ? wdata_q : 16'bz;
  // Sequencer: strobes and bus address are registered at acceptance and dropped when the access completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      bus_addr_q <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      read_q <= 1'b0;
      write_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req) begin
          if (fault) begin
            state_q <= DONE;
            ack_q <= 1'b1;
            err_q <= 1'b1;
          end else begin
            state_q <= ACCESS;
            cnt_q <= 4'(WAIT_CYCLES);
            bus_addr_q <= addr;
            wdata_q <= wdata;
            read_q <= ~we;
            write_q <= we;
          end
        end
        ACCESS: if (cnt_q != 4'd0) begin
          cnt_q <= cnt_q - 4'd1;
        end else begin
          if (read_q) rdata_q <= bus_data;
          state_q <= DONE;
          ack_q <= 1'b1;
          bus_addr_q <= '0;
          read_q <= 1'b0;
          write_q <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
          ack_q <= 1'b0;
          err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: randomized transactions against a word-memory reference model with a simple bus responder.
module tb_bus_master;
  localparam int W = 2;
`ifdef BUS_RANGE_CHECK_EN
  localparam int LO = 'h100;
  localparam int HI = 'h110;
`else
  localparam int LO = 0;
  localparam int HI = 1 << 20;
`endif
  localparam logic [19:0] BASE = 20'(LO);
  logic clk = 0, reset = 1, req = 0, we = 0;
  logic [19:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata;
  logic ack, err, busy, read, write;
  logic [19:0] bus_addr;
  wire [15:0] bus_data;
  int checks = 0, failures = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] bmem [256];
  logic [15:0] exp_rdata = '0;

  bus_master #(.WAIT_CYCLES(W), .MAP_START(LO), .MAP_SIZE(HI - LO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy), .bus_addr(bus_addr),
    .bus_data(bus_data), .read(read), .write(write)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] seed(int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  function automatic bit faulty(logic [19:0] a);
    return int'({12'b0, a}) < LO || int'({12'b0, a}) >= HI;
  endfunction

  assign bus_data = read ? bmem[bus_addr[7:0]] : 16'bz;

  initial begin
    for (int i = 0; i < 256; i++) bmem[i] = seed(i);
    forever begin
      @(posedge clk);
      if (write) bmem[bus_addr[7:0]] = bus_data;
    end
  end

  task automatic run_txn(input bit w, input logic [19:0] a, input logic [15:0] d);
    bit f;
    int ap;
    bit st;
    f = faulty(a);
    ap = f ? 0 : W + 1;
    req = 1; we = w; addr = a; wdata = d;
    @(posedge clk); #1;
    if (!f && w) ref_mem[a[7:0]] = d;
    if (!f && !w) exp_rdata = ref_mem[a[7:0]];
    for (int j = 0; j <= ap + 1; j++) begin
      if (j > 0) begin
        @(posedge clk); #1;
      end else begin
        req = 1'($urandom); we = 1'($urandom); addr = 20'($urandom); wdata = 16'($urandom);
      end
      st = !f && j <= W;
      checks++;
      if ({read, write} !== {st && !w, st && w}) begin
        failures++;
        $display("FAIL strobe a=%h j=%0d got rd/wr=%b%b want %b%b", a, j, read, write, st && !w, st && w);
      end
      checks++;
      if (bus_addr !== (st ? a : 20'h0)) begin
        failures++;
        $display("FAIL bus_addr j=%0d got %h want %h", j, bus_addr, st ? a : 20'h0);
      end
      if (st) begin
        checks++;
        if (bus_data !== (w ? d : exp_rdata)) begin
          failures++;
          $display("FAIL bus_data a=%h j=%0d got %h want %h", a, j, bus_data, w ? d : exp_rdata);
        end
      end
      checks++;
      if ({ack, err, busy} !== {j == ap, f && j == ap, j <= ap}) begin
        failures++;
        $display("FAIL ack_err_busy a=%h j=%0d got %b want %b", a, j, {ack, err, busy}, {j == ap, f && j == ap, j <= ap});
      end
      if (j == ap) begin
        checks++;
        if (rdata !== exp_rdata) begin
          failures++;
          $display("FAIL rdata a=%h got %h want %h", a, rdata, exp_rdata);
        end
        req = 0;
      end
    end
    if (w && !f) begin
      checks++;
      if (bmem[a[7:0]] !== d) begin
        failures++;
        $display("FAIL mem_write a=%h got %h want %h", a, bmem[a[7:0]], d);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({rdata, ack, err, busy, bus_addr, read, write} !== '0) begin
      failures++;
      $display("FAIL reset_state got rdata=%h ack=%b err=%b busy=%b addr=%h rd=%b wr=%b want all 0",
               rdata, ack, err, busy, bus_addr, read, write);
    end
    reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(1, 20'h00010, 16'hBEEF);
    run_txn(0, 20'h00010, 16'h0000);
  endtask

  task automatic test_boundaries();
    run_txn(0, 20'h00110, 16'h0000);
    run_txn(1, 20'h0010F, 16'hC0DE);
    run_txn(0, 20'h0010F, 16'h0000);
    run_txn(0, 20'hFFFFF, 16'h0000);
    run_txn(0, BASE, 16'h0000);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic [19:0] a;
      a = ($urandom_range(0, 4) == 0) ? 20'($urandom) : BASE + 20'($urandom_range(0, 15));
      run_txn(1'($urandom), a, 16'($urandom));
    end
  endtask

  task automatic test_back_to_back();
    int acc2 = -1, acks = 0;
    logic [15:0] r [2];
    bit pb;
    r[0] = '0; r[1] = '0;
    req = 1; we = 0; addr = BASE + 20'd1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_accept got busy=%b want 1", busy);
    end
    pb = busy;
    addr = BASE + 20'd2;
    for (int t = 1; t <= 2 * W + 5; t++) begin
      @(posedge clk); #1;
      if (busy && !pb && acc2 < 0) acc2 = t;
      if (ack) begin
        if (acks < 2) r[acks] = rdata;
        acks++;
      end
      pb = busy;
      if (t == 2 * W + 5) req = 0;
    end
    exp_rdata = ref_mem[2];
    checks++;
    if (acc2 != W + 3) begin
      failures++;
      $display("FAIL b2b_spacing got %0d want %0d", acc2, W + 3);
    end
    checks++;
    if (acks != 2) begin
      failures++;
      $display("FAIL b2b_ack_count got %0d want 2", acks);
    end
    checks++;
    if (r[0] !== ref_mem[1] || r[1] !== ref_mem[2]) begin
      failures++;
      $display("FAIL b2b_rdata got %h,%h want %h,%h", r[0], r[1], ref_mem[1], ref_mem[2]);
    end
  endtask

  task automatic test_reset_abort();
    run_txn(1, BASE + 20'd3, 16'h1234);
    run_txn(0, BASE + 20'd3, 16'h0000);
    checks++;
    if (rdata !== 16'h1234) begin
      failures++;
      $display("FAIL abort_pre_rdata got %h want 1234", rdata);
    end
    req = 1; we = 0; addr = BASE + 20'd4;
    @(posedge clk); #1;
    req = 0;
    @(posedge clk); #1;
    checks++;
    if (read !== 1'b1) begin
      failures++;
      $display("FAIL abort_second_strobe got read=%b want 1", read);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({read, write, busy, ack, rdata} !== '0) begin
      failures++;
      $display("FAIL abort_immediate got rd=%b wr=%b busy=%b ack=%b rdata=%h want all 0", read, write, busy, ack, rdata);
    end
    @(posedge clk); #1;
    reset = 0;
    exp_rdata = '0;
    for (int t = 0; t < W + 3; t++) begin
      @(posedge clk); #1;
      checks++;
      if (ack !== 1'b0 || busy !== 1'b0 || rdata !== 16'h0) begin
        failures++;
        $display("FAIL abort_no_ack t=%0d got ack=%b busy=%b rdata=%h want 0 0 0000", t, ack, busy, rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
    test_reset();
    test_directed();
    test_boundaries();
    test_random();
    test_back_to_back();
    test_reset_abort();
    run_txn(0, BASE + 20'd5, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_master.md
BUS_MASTER -- requirements
Module: bus_master

Interface
REQ-001 Parameter WAIT_CYCLES, default 0: extra strobe cycles beyond one, range 0..15.
REQ-002 Parameter MAP_START, default 0: first valid bus address; used only when BUS_RANGE_CHECK_EN is defined.
REQ-003 Parameter MAP_SIZE, default 1024: number of valid words from MAP_START; used only when BUS_RANGE_CHECK_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  CPU access request; sampled only in IDLE.
REQ-007 we  input  1  1 = write, 0 = read; sampled with req.
REQ-008 addr  input  20  CPU word address; sampled with req.
REQ-009 wdata  input  16  CPU write data; sampled with req.
REQ-010 rdata  output  16  last read result; holds its value between reads.
REQ-011 ack  output  1  one-cycle completion pulse.
REQ-012 err  output  1  address-fault flag; valid while ack=1.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 bus_addr  output  20  shared bus address.
REQ-015 bus_data  inout  16  shared bus data; tristated when not writing.
REQ-016 read  output  1  bus read strobe.
REQ-017 write  output  1  bus write strobe; responders capture on a rising edge while it is high.

Function
REQ-018 FSM states: IDLE, ACCESS, DONE; all outputs registered or decoded from registered state only.
REQ-019 IDLE with req=1 at edge k: latch we/addr/wdata; go to ACCESS; load counter with WAIT_CYCLES.
REQ-020 IDLE with req=0: no change; bus_addr=0, read=0, write=0, bus_data=Z.
REQ-021 ACCESS: bus_addr=latched addr; read=~we_l; write=we_l; bus_data=wdata_l if we_l, else Z.
REQ-022 ACCESS, counter>0: decrement only; strobe width is WAIT_CYCLES+1 cycles.
REQ-023 ACCESS, counter=0: on a read, rdata<=bus_data; go to DONE.
REQ-024 DONE: strobes low; bus_data=Z; ack=1 for exactly one cycle; then IDLE.
REQ-025 Latency: ack is high in the cycle after edge k+WAIT_CYCLES+1; earliest next acceptance is edge k+WAIT_CYCLES+3.
REQ-026 req in ACCESS or DONE is ignored, not queued; inputs changing after edge k have no effect.
REQ-027 read and write are never both high; bus_data is never driven while read=1.
REQ-028 busy=1 in ACCESS and DONE; err=0 whenever ack=0.

Reset
REQ-029 reset=1 forces IDLE immediately, independent of clk.
REQ-030 On reset: rdata=0, ack=0, err=0, busy=0, counter=0, bus_addr=0, read=0, write=0, bus_data=Z.
REQ-031 Reset during ACCESS aborts the transfer: no ack is produced, and a read does not update rdata.

Configuration
REQ-032 Macro BUS_RANGE_CHECK_EN defined: at acceptance, addr < MAP_START or addr > MAP_START+MAP_SIZE-1 bypasses ACCESS.
REQ-033 Out-of-range request: go to DONE directly, ack=1, err=1, rdata unchanged, no strobe; latency is one edge.
REQ-034 BUS_RANGE_CHECK_EN defined, in-range request: err=0 with ack.
REQ-035 BUS_RANGE_CHECK_EN undefined: err tied 0; every address issued; MAP_START/MAP_SIZE unused.

Verification
REQ-036 WAIT_CYCLES=0, write addr=0x00010 wdata=0xBEEF -> write high 1 cycle, bus_data=0xBEEF, bus_addr=0x00010; ack in the following cycle; memory word 0x10=0xBEEF.
REQ-037 WAIT_CYCLES=2, read addr=0x00010 after REQ-036 -> read high 3 cycles; rdata=0xBEEF; ack one cycle later; bus_data never driven by bus_master.
REQ-038 req held high continuously, reads to 0x1, 0x2 -> acceptances spaced WAIT_CYCLES+3 edges apart; exactly one ack per transfer.
REQ-039 reset pulsed in the second strobe cycle of a read (WAIT_CYCLES=2, rdata=0x1234 beforehand) -> strobes drop immediately; no ack; rdata=0 after reset.
REQ-040 BUS_RANGE_CHECK_EN defined, MAP_START=0x100, MAP_SIZE=0x10, read addr=0x110 -> no strobe; ack=1 and err=1 one cycle after acceptance. Address 0x10F -> normal access, err=0.
REQ-041 BUS_RANGE_CHECK_EN undefined, read addr=0xFFFFF -> read strobe issued; err=0; ack after WAIT_CYCLES+2 edges.
